// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchronizer, stability counter debounce,
// and one-cycle press/release pulses.
// Optional auto-repeat on held keys is enabled by defining the macro
// KEY_DEBOUNCE_REPEAT_EN; the default build has no repeat logic at all.
module key_debounce #(
    parameter int N_KEYS        = 5,
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int            CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] toggle;
    logic [N_KEYS-1:0] rep_fire;
    logic [CW-1:0]     db_cnt [N_KEYS];

    // Two-flop synchronizer on the raw switch inputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // A key flips once its input has differed from the level for DB_CYCLES cycles
    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            toggle[i] = (sync2[i] != key_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Stability counters: clear on agreement or on acceptance, else count up
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if ((sync2[i] == key_level[i]) || toggle[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced level and edge pulses, registered together with the toggle
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_level   <= key_level ^ toggle;
            key_press   <= (toggle & ~key_level) | rep_fire;
            key_release <= toggle & key_level;
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int            REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW        = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt [N_KEYS];

    // Repeat fires at terminal count while held; suppressed on the release edge
    // so press and release never coincide
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rep_fire[i] = key_level[i] && !toggle[i] && (rep_cnt[i] == '0);
        end
    end

    // Repeat down-counters: load on accepted press, reload on each repeat, clear when released
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < N_KEYS; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (toggle[i] && !key_level[i]) begin
                    rep_cnt[i] <= REP_FIRST;
                end else if (!key_level[i] || toggle[i]) begin
                    rep_cnt[i] <= '0;
                end else if (rep_cnt[i] == '0) begin
                    rep_cnt[i] <= REP_NEXT;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] - RW'(1);
                end
            end
        end
    end
`else
    // No auto-repeat: only accepted presses produce key_press
    always_comb begin
        rep_fire = '0;
    end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, N_KEYS=5. Edge numbering: edge 1 is the first rising
// clk edge that samples a changed key_in; outputs are sampled 1 ns after
// each rising edge, and inputs are changed at the same point.
module tb_key_debounce;

    localparam int N_KEYS = 5;

    logic              clk;
    logic              rstb;
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    int n_tests;
    int n_fail;

    key_debounce #(
        .N_KEYS        (N_KEYS),
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N_KEYS-1:0] obs, input logic [N_KEYS-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected key_press[0] at edge e for a key held for `hold` sampling edges.
    // Press accepted at edge 6; with repeat, extra pulses at 16, 19, 22, ...
    // while the level is still high (level falls at edge hold+6).
    function automatic logic exp_press0(int e, int hold);
        if (e == 6) return 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        if (e >= 16 && e < hold + 6 && ((e - 16) % 3) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Key 0 held for `hold` edges, then released; checked every edge
    task automatic run_hold(input int hold);
        logic [N_KEYS-1:0] e_lvl;
        logic [N_KEYS-1:0] e_prs;
        logic [N_KEYS-1:0] e_rel;
        key_in[0] = 1'b1;
        for (int e = 1; e <= hold + 8; e++) begin
            if (e == hold + 1) key_in[0] = 1'b0;
            tick();
            e_lvl = '0;
            e_prs = '0;
            e_rel = '0;
            e_lvl[0] = (e >= 6) && (e < hold + 6);
            e_prs[0] = exp_press0(e, hold);
            e_rel[0] = (e == hold + 6);
            check($sformatf("hold%0d_level_e%0d", hold, e), key_level, e_lvl);
            check($sformatf("hold%0d_press_e%0d", hold, e), key_press, e_prs);
            check($sformatf("hold%0d_release_e%0d", hold, e), key_release, e_rel);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstb    = 1'b0;
        key_in  = '0;

        // Reset state
        tick();
        tick();
        check("reset_level", key_level, 5'b00000);
        check("reset_press", key_press, 5'b00000);
        check("reset_release", key_release, 5'b00000);
        rstb = 1'b1;
        tick();
        tick();

        // Clean press/release on key 0 (20 cycles), then a 30-cycle hold
        run_hold(20);
        run_hold(30);

        // Key 1 bounce train with 3-cycle runs: nothing may change
        for (int r = 0; r < 4; r++) begin
            key_in[1] = (r % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick();
                check($sformatf("bounce_level_r%0d_c%0d", r, c), key_level, 5'b00000);
                check($sformatf("bounce_press_r%0d_c%0d", r, c), key_press, 5'b00000);
            end
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("bounce_tail_level_%0d", c), key_level, 5'b00000);
            check($sformatf("bounce_tail_press_%0d", c), key_press, 5'b00000);
            check($sformatf("bounce_tail_release_%0d", c), key_release, 5'b00000);
        end

        // Keys 2 and 4 rise together
        key_in = 5'b10100;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("dual_nopress_e%0d", e), key_press, 5'b00000);
        end
        tick();
        check("dual_press_e6", key_press, 5'b10100);
        check("dual_level_e6", key_level, 5'b10100);
        tick();
        check("dual_press_e7", key_press, 5'b00000);
        key_in = 5'b00000;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("dual_norel_e%0d", e), key_release, 5'b00000);
            check($sformatf("dual_held_level_e%0d", e), key_level, 5'b10100);
        end
        tick();
        check("dual_release_e6", key_release, 5'b10100);
        check("dual_level_low_e6", key_level, 5'b00000);
        check("dual_press_at_release", key_press, 5'b00000);
        tick();
        check("dual_release_e7", key_release, 5'b00000);

        // Key 3: reset at counter value 3 discards progress
        key_in[3] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("rst_prepress_e%0d", e), key_press, 5'b00000);
        end
        rstb = 1'b0;
        tick();
        check("rst_hold_press", key_press, 5'b00000);
        tick();
        check("rst_hold_level", key_level, 5'b00000);
        rstb = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("rst_post_nopress_e%0d", e), key_press, 5'b00000);
            check($sformatf("rst_post_level_e%0d", e), key_level, 5'b00000);
        end
        tick();
        check("rst_post_press_e6", key_press, 5'b01000);
        check("rst_post_level_e6", key_level, 5'b01000);

        // Asynchronous reset clears a held level without a clock edge
        #2;
        rstb = 1'b0;
        #1;
        check("async_rst_level", key_level, 5'b00000);
        check("async_rst_press", key_press, 5'b00000);
        key_in = '0;
        tick();
        rstb = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
